// File: rtl/seg7_cap_pkg.sv
// rtl/seg7_cap_pkg.sv - segment codes, digit/BCD types and select helpers for the scan capture
package seg7_cap_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  // Digit index follows select bit position: 5=hour_h ... 0=sec_l
  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_HELD
  } cap_state_t;

  function automatic logic sel_is_one_low(input logic [5:0] sel);
    return $onehot(~sel);
  endfunction

  function automatic digit_idx_t sel_to_idx(input logic [5:0] sel);
    digit_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel[i]) idx = digit_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational seven-segment to BCD decoder with legality flag
module seg7_decode
  import seg7_cap_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd   = '0;
    legal = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - debounced capture of a scanned 6-digit HH:MM:SS display into a time frame
// Optional illegal-pattern counter enabled by defining SEG7_CAP_ERR_EN.
module seg7_scan_capture
  import seg7_cap_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] num0_scan_select,
  input  logic [6:0] num0_seg7,
  output logic [1:0] hour_h,
  output logic [3:0] hour_l,
  output logic [2:0] min_h,
  output logic [3:0] min_l,
  output logic [2:0] sec_h,
  output logic [3:0] sec_l,
  output logic       time_valid,
  output logic       frame_pulse,
  output logic       changed_pulse,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

  logic [5:0]  sel_q;
  logic [6:0]  seg_q;
  logic [12:0] cand;
  logic [7:0]  count;
  cap_state_t  state, state_nxt;
  logic        blank, same, reach, accept;
  logic [3:0]  dec_bcd;
  logic        dec_legal;
  digit_idx_t  idx;

  logic [5:0][3:0] shadow;
  logic [5:0][3:0] shown;
  logic [5:0]      mask;
  logic            first_done;
  logic            in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '1;
      seg_q <= '0;
    end else begin
      sel_q <= num0_scan_select;
      seg_q <= num0_seg7;
    end
  end

  seg7_decode u_decode (
    .seg   (seg_q),
    .bcd   (dec_bcd),
    .legal (dec_legal)
  );

  assign blank = !sel_is_one_low(sel_q);
  assign same  = ({sel_q, seg_q} == cand);
  assign idx   = sel_to_idx(sel_q);
  assign reach = (state == ST_DWELL) && same && (count == LAST_COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (blank)                             state_nxt = ST_IDLE;
    else if (state == ST_IDLE || !same)    state_nxt = ST_DWELL;
    else if (reach)                        state_nxt = ST_HELD;
  end

  always_comb begin
    accept = reach && dec_legal;
  end

  // Candidate sample and dwell counter; a changed sample restarts the dwell at 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand  <= '0;
      count <= '0;
    end else if (blank) begin
      count <= '0;
    end else if (state == ST_IDLE || !same) begin
      cand  <= {sel_q, seg_q};
      count <= 8'd1;
    end else if (state == ST_DWELL) begin
      count <= count + 8'd1;
    end
  end

  assign in_range = (shadow[5] <= 4'd2) && !(shadow[5] == 4'd2 && shadow[4] > 4'd3) &&
                    (shadow[3] <= 4'd5) && (shadow[1] <= 4'd5);

  // A completed mask publishes the shadows; an acceptance on that same cycle seeds the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow        <= '0;
      shown         <= '0;
      mask          <= '0;
      first_done    <= 1'b0;
      frame_pulse   <= 1'b0;
      changed_pulse <= 1'b0;
      time_valid    <= 1'b0;
    end else begin
      frame_pulse   <= 1'b0;
      changed_pulse <= 1'b0;
      if (mask == 6'h3F) begin
        shown         <= shadow;
        frame_pulse   <= 1'b1;
        changed_pulse <= first_done && (shadow != shown);
        time_valid    <= in_range;
        first_done    <= 1'b1;
        mask          <= accept ? (6'd1 << idx) : 6'd0;
      end else if (accept) begin
        mask[idx] <= 1'b1;
      end
      if (accept) shadow[idx] <= dec_bcd;
    end
  end

  assign hour_h = shown[5][1:0];
  assign hour_l = shown[4];
  assign min_h  = shown[3][2:0];
  assign min_l  = shown[2];
  assign sec_h  = shown[1][2:0];
  assign sec_l  = shown[0];

`ifdef SEG7_CAP_ERR_EN
  logic       reject;
  logic [7:0] err_q;

  assign reject = reach && !dec_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_q <= '0;
    else if (reject && err_q != 8'hFF)  err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - directed self-checking bench for seg7_scan_capture
module tb_seg7_scan_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] sel;
  logic [6:0] seg;
  logic [1:0] hour_h;
  logic [3:0] hour_l;
  logic [2:0] min_h;
  logic [3:0] min_l;
  logic [2:0] sec_h;
  logic [3:0] sec_l;
  logic       time_valid, frame_pulse, changed_pulse;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int changes = 0;
  int f0, c0;
  int exp_err;

  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  seg7_scan_capture #(.STABLE_CYCLES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .num0_scan_select (sel),
    .num0_seg7        (seg),
    .hour_h           (hour_h),
    .hour_l           (hour_l),
    .min_h            (min_h),
    .min_l            (min_l),
    .sec_h            (sec_h),
    .sec_l            (sec_l),
    .time_valid       (time_valid),
    .frame_pulse      (frame_pulse),
    .changed_pulse    (changed_pulse),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (frame_pulse)   frames++;
    if (changed_pulse) changes++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    sel = 6'h3F;
    seg = 7'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_raw(input int pos, input logic [6:0] code, input int n);
    sel = 6'h3F ^ (6'd1 << pos);
    seg = code;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int pos, input int val, input int n);
    show_raw(pos, seg_tab[val], n);
  endtask

  task automatic scan(input logic [23:0] t, input int n);
    for (int p = 5; p >= 0; p--) show(p, int'(t[p*4 +: 4]), n);
    idle(4);
  endtask

  initial begin
`ifdef SEG7_CAP_ERR_EN
    exp_err = 3;
`else
    exp_err = 0;
`endif
    reset = 1'b1;
    sel = 6'h3F;
    seg = 7'h00;
    repeat (3) @(negedge clk);
    check("rst_hour_h", 32'(hour_h), 0);
    check("rst_sec_l", 32'(sec_l), 0);
    check("rst_valid", 32'(time_valid), 0);
    check("rst_frame", 32'(frame_pulse), 0);
    check("rst_changed", 32'(changed_pulse), 0);
    check("rst_err", 32'(err_cnt), 0);
    reset = 1'b0;
    idle(3);

    // 12:34:56 with long dwell
    f0 = frames; c0 = changes;
    scan(24'h123456, 1024);
    check("f1_frames", 32'(frames - f0), 1);
    check("f1_changed", 32'(changes - c0), 0);
    check("f1_hour_h", 32'(hour_h), 1);
    check("f1_hour_l", 32'(hour_l), 2);
    check("f1_min_h", 32'(min_h), 3);
    check("f1_min_l", 32'(min_l), 4);
    check("f1_sec_h", 32'(sec_h), 5);
    check("f1_sec_l", 32'(sec_l), 6);
    check("f1_valid", 32'(time_valid), 1);

    // 12:34:57 differs in sec_l
    f0 = frames; c0 = changes;
    scan(24'h123457, 20);
    check("f2_frames", 32'(frames - f0), 1);
    check("f2_changed", 32'(changes - c0), 1);
    check("f2_sec_l", 32'(sec_l), 7);
    check("f2_min_l", 32'(min_l), 4);

    // Short dwell on the last digit must not complete the frame; min_l re-captured later wins
    f0 = frames; c0 = changes;
    show(5, 0, 20); show(4, 8, 20); show(3, 1, 20); show(2, 5, 20); show(1, 3, 20);
    show(2, 7, 20);
    show(0, 9, 10);
    idle(4);
    check("short_frames", 32'(frames - f0), 0);
    check("short_sec_l", 32'(sec_l), 7);
    show(0, 9, 20);
    idle(4);
    check("f3_frames", 32'(frames - f0), 1);
    check("f3_changed", 32'(changes - c0), 1);
    check("f3_hour_h", 32'(hour_h), 0);
    check("f3_hour_l", 32'(hour_l), 8);
    check("f3_min_l", 32'(min_l), 7);
    check("f3_sec_l", 32'(sec_l), 9);
    check("f3_valid", 32'(time_valid), 1);

    // 29:00:00 is output but out of range
    f0 = frames;
    scan(24'h290000, 20);
    check("f4_frames", 32'(frames - f0), 1);
    check("f4_hour_h", 32'(hour_h), 2);
    check("f4_hour_l", 32'(hour_l), 9);
    check("f4_min_l", 32'(min_l), 0);
    check("f4_valid", 32'(time_valid), 0);

    // Undecodable pattern on min_l for three dwells
    f0 = frames;
    repeat (3) begin
      show_raw(2, 7'b1010101, 20);
      idle(3);
    end
    check("bad_frames", 32'(frames - f0), 0);
    check("bad_err", 32'(err_cnt), 32'(exp_err));

    // Reset after three captured digits
    show(5, 2, 20); show(4, 1, 20); show(3, 4, 20);
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_hour_l", 32'(hour_l), 0);
    check("mid_rst_min_l", 32'(min_l), 0);
    check("mid_rst_valid", 32'(time_valid), 0);
    check("mid_rst_err", 32'(err_cnt), 0);
    reset = 1'b0;
    f0 = frames; c0 = changes;
    show(2, 5, 20); show(1, 0, 20); show(0, 3, 20);
    idle(4);
    check("post_rst_partial", 32'(frames - f0), 0);
    scan(24'h214503, 20);
    check("post_rst_frames", 32'(frames - f0), 1);
    check("post_rst_changed", 32'(changes - c0), 0);
    check("post_rst_hour_h", 32'(hour_h), 2);
    check("post_rst_hour_l", 32'(hour_l), 1);
    check("post_rst_min_h", 32'(min_h), 4);
    check("post_rst_sec_l", 32'(sec_l), 3);
    check("post_rst_valid", 32'(time_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
